// File: rtl/matrix_framebuffer.sv
// matrix_framebuffer: 8x8 RGB pixel store for an LED matrix driver.
//
// Optional feature macro: MATRIX_FB_DOUBLE_BUFFER_EN
//   defined   : two banks; writes/clears go to the back bank, reads come from
//               the front bank, and swaps are taken on frame boundaries.
//   undefined : one bank; writes/clears go to the displayed bank, front_bank
//               stays 0, and the swap_req/frame_done/swap_ack handshake still
//               runs without toggling anything.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   wr_en/wr_x/wr_y/wr_rgb: pixel write, accepted when wr_ready=1
//   wr_ready              : ~clear_busy
//   clear_req, clear_busy : back-bank clear, one row per cycle for 8 cycles
//   swap_req, swap_pending: swap request and its pending flag
//   swap_ack              : one-cycle pulse, high in the first cycle of the new front bank
//   frame_done            : frame boundary from the driver
//   rd_row                : row to read, data appears one cycle later
//   rd_red/green/blue     : front-bank row data, bit i = column i
//   front_bank            : index of the displayed bank
module matrix_framebuffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_x,
    input  logic [2:0] wr_y,
    input  logic [2:0] wr_rgb,
    output logic       wr_ready,
    input  logic       clear_req,
    output logic       clear_busy,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       swap_ack,
    input  logic       frame_done,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_red,
    output logic [7:0] rd_green,
    output logic [7:0] rd_blue,
    output logic       front_bank
);

    typedef enum logic {
        CLR_IDLE,
        CLR_BUSY
    } clr_state_e;

    clr_state_e clr_state_q, clr_state_d;
    logic [2:0] clr_row_q, clr_row_d;
    logic       swap_pending_q, swap_pending_d;
    logic       swap_ack_q, swap_ack_d;
    logic       front_q, front_d;
    logic       back_bank;
    logic       busy;
    logic       do_swap;

    logic [7:0] red_q   [2][8];
    logic [7:0] green_q [2][8];
    logic [7:0] blue_q  [2][8];
    logic [7:0] rd_red_q, rd_green_q, rd_blue_q;

    assign busy = (clr_state_q == CLR_BUSY);

    // Clear sequencer: walks rows 0..7, one per cycle.
    always_comb begin
        clr_state_d = clr_state_q;
        clr_row_d   = clr_row_q;
        case (clr_state_q)
            CLR_IDLE: begin
                if (clear_req) begin
                    clr_state_d = CLR_BUSY;
                    clr_row_d   = '0;
                end
            end
            CLR_BUSY: begin
                clr_row_d = clr_row_q + 3'd1;
                if (clr_row_q == 3'd7) begin
                    clr_state_d = CLR_IDLE;
                end
            end
            default: clr_state_d = CLR_IDLE;
        endcase
    end

    // A swap is never taken mid-clear, so the back bank is stable for the
    // whole clear; a clear started in the swap cycle therefore lands on the
    // post-swap back bank.
    always_comb begin
        do_swap        = frame_done && (swap_pending_q || swap_req) && !busy;
        swap_pending_d = do_swap ? 1'b0 : (swap_pending_q || swap_req);
        swap_ack_d     = do_swap;
`ifdef MATRIX_FB_DOUBLE_BUFFER_EN
        front_d   = front_q ^ do_swap;
        back_bank = ~front_q;
`else
        front_d   = 1'b0;
        back_bank = front_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_state_q    <= CLR_IDLE;
            clr_row_q      <= '0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            front_q        <= 1'b0;
            rd_red_q       <= '0;
            rd_green_q     <= '0;
            rd_blue_q      <= '0;
            red_q          <= '{default: '0};
            green_q        <= '{default: '0};
            blue_q         <= '{default: '0};
        end else begin
            clr_state_q    <= clr_state_d;
            clr_row_q      <= clr_row_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
            front_q        <= front_d;

            if (wr_en && !busy) begin
                red_q  [back_bank][wr_y][wr_x] <= wr_rgb[2];
                green_q[back_bank][wr_y][wr_x] <= wr_rgb[1];
                blue_q [back_bank][wr_y][wr_x] <= wr_rgb[0];
            end
            if (busy) begin
                red_q  [back_bank][clr_row_q] <= '0;
                green_q[back_bank][clr_row_q] <= '0;
                blue_q [back_bank][clr_row_q] <= '0;
            end

            rd_red_q   <= red_q  [front_q][rd_row];
            rd_green_q <= green_q[front_q][rd_row];
            rd_blue_q  <= blue_q [front_q][rd_row];
        end
    end

    assign wr_ready     = ~busy;
    assign clear_busy   = busy;
    assign swap_pending = swap_pending_q;
    assign swap_ack     = swap_ack_q;
    assign front_bank   = front_q;
    assign rd_red       = rd_red_q;
    assign rd_green     = rd_green_q;
    assign rd_blue      = rd_blue_q;

endmodule

// File: doc/matrix_framebuffer.md
MATRIX_FRAMEBUFFER -- requirements
Module: matrix_framebuffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all other ports are synchronous to clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 wr_en  input  1  pixel write request; accepted only when wr_ready=1.
REQ-005 wr_x  input  3  write column 0..7.
REQ-006 wr_y  input  3  write row 0..7.
REQ-007 wr_rgb  input  3  {red,green,blue} pixel bits, 1 = lit (active-high here; the driver inverts).
REQ-008 wr_ready  output  1  high when a write can be accepted.
REQ-009 clear_req  input  1  single-cycle pulse: clear the back bank.
REQ-010 clear_busy  output  1  high while a clear is in progress.
REQ-011 swap_req  input  1  single-cycle pulse: request a front/back bank swap.
REQ-012 swap_pending  output  1  swap requested, not yet performed.
REQ-013 swap_ack  output  1  one-cycle pulse, cycle after the swap takes effect.
REQ-014 frame_done  input  1  pulse from the matrix driver when row 7 finishes (frame boundary).
REQ-015 rd_row  input  3  row requested by the driver.
REQ-016 rd_red, rd_green, rd_blue  output  8 each  front-bank row data, bit i = column i.
REQ-017 front_bank  output  1  index of the displayed bank.

Function
REQ-018 SHALL store 2 banks x 8 rows x 24 bits in flops; back bank = ~front_bank.
REQ-019 wr_ready SHALL equal ~clear_busy; a write with wr_en=1 and wr_ready=0 SHALL be dropped.
REQ-020 An accepted write SHALL update only the three bits at (wr_x, wr_y) of the back bank, visible in storage the next cycle.
REQ-021 Read latency SHALL be 1: rd_* in cycle N+1 = front-bank row rd_row sampled in cycle N.
REQ-022 clear_req while clear_busy=0 SHALL zero back-bank rows 0..7, one row per cycle, clear_busy high exactly 8 cycles; clear_req while busy SHALL be ignored.
REQ-023 swap_req SHALL set swap_pending the next cycle; extra swap_req while pending has no effect.
REQ-024 On frame_done with (swap_pending or swap_req same cycle) and clear_busy=0, front_bank SHALL toggle next cycle, swap_pending clear, swap_ack pulse one cycle.
REQ-025 frame_done during clear_busy SHALL defer the swap to the next qualifying frame_done; pending stays set.
REQ-026 A write in the swap cycle SHALL go to the pre-swap back bank.
REQ-027 clear_req in the swap cycle SHALL target the post-swap back bank.
REQ-028 Reads in the cycle after the swap SHALL return the new front bank.

Reset
REQ-029 Reset SHALL zero both banks, front_bank=0, rd_*=0, swap_pending=0, swap_ack=0, clear_busy=0 (wr_ready=1), next cycle.
REQ-030 Reset mid-clear or with swap pending SHALL abort the operation; no swap_ack is issued.
REQ-031 Reset SHALL override every simultaneous input.

Configuration
REQ-032 Macro MATRIX_FB_DOUBLE_BUFFER_EN defined: behaviour as above.
REQ-033 Undefined: single bank; writes and clears target the displayed bank; front_bank tied 0; swap_req still sets pending and frame_done still produces swap_ack (frame-sync handshake kept, no bank toggle).

Verification
REQ-034 Reset; write (x=3,y=5,rgb=3'b101); swap_req; frame_done; rd_row=5 -> front_bank=1, swap_ack one pulse, rd_red=8'h08, rd_green=8'h00, rd_blue=8'h08.
REQ-035 clear_req then wr_en on next 8 cycles -> clear_busy high exactly 8 cycles, all 8 writes dropped, back bank all zero.
REQ-036 swap_req; clear_req; frame_done during clear -> no swap; frame_done after clear -> swap, swap_ack once.
REQ-037 swap_req and frame_done same cycle, plus write (x=0,y=0,rgb=3'b111) -> swap occurs; read row 0 next cycle shows rd_*=8'h01 each.
REQ-038 Reset asserted with swap_pending=1 and clear_busy=1 -> next cycle all outputs at reset values, later frame_done gives no swap_ack.
REQ-039 Without MATRIX_FB_DOUBLE_BUFFER_EN: write (x=7,y=2,rgb=3'b010), rd_row=2 -> rd_green=8'h80 two cycles later; swap_req+frame_done -> swap_ack, front_bank=0.
